// File: rtl/rotate_pkg.sv
// Shared types and helpers for the rotation frame-store buffer scheduler.
//   buf_idx_t  : region index, 0..2
//   BUF_*_RST  : region each role owns out of reset (writer, reader, pending)
//   state_t    : SYNC waits for the first frame boundary, RUN publishes frames
//   buf_base() : first word address of a region
//   sat_inc8() : 8-bit increment that sticks at 255
package rotate_pkg;

    typedef logic [1:0] buf_idx_t;

    localparam buf_idx_t BUF_W_RST = 2'd0;
    localparam buf_idx_t BUF_R_RST = 2'd1;
    localparam buf_idx_t BUF_P_RST = 2'd2;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned buf_base(input buf_idx_t idx, input int unsigned bufsize);
        return int'(unsigned'({30'd0, idx})) * bufsize;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rotate_frame_validator.sv
// Writer-side frame qualifier.
// Detects line starts (hblank rising outside vblank) and frame ends (vblank
// rising), and counts lines so the scheduler can tell whether the frame that
// just ended was complete.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : 0 suppresses frame_end and holds the line count at zero
//   wr_hbl      : writer hblank level
//   wr_vbl      : writer vblank level
//   frame_end   : one-cycle pulse on vblank rising (gated by enable)
//   frame_ok    : at least HEIGHT lines were seen since the last frame end
module rotate_frame_validator #(
    parameter int HEIGHT = 240
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic wr_hbl,
    input  logic wr_vbl,
    output logic frame_end,
    output logic frame_ok
);

    localparam int LCW = $clog2(HEIGHT + 2);
    localparam logic [LCW-1:0] LC_MAX    = '1;
    localparam logic [LCW-1:0] LC_HEIGHT = LCW'(HEIGHT);

    logic           hbl_q, hbl_d;
    logic           vbl_q, vbl_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic           line_event;
    logic           vbl_rise;

    always_comb begin
        hbl_d      = wr_hbl;
        vbl_d      = wr_vbl;
        line_event = wr_hbl & ~hbl_q & ~wr_vbl;
        vbl_rise   = wr_vbl & ~vbl_q;
        line_cnt_d = line_cnt_q;
        // Count is cleared at every frame boundary so each frame is judged
        // on its own lines only; saturation keeps a long frame "ok".
        if (!enable || vbl_rise) begin
            line_cnt_d = '0;
        end else if (line_event && (line_cnt_q != LC_MAX)) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            hbl_q      <= hbl_d;
            vbl_q      <= vbl_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign frame_end = enable & vbl_rise;
    assign frame_ok  = (line_cnt_q >= LC_HEIGHT);

endmodule

// File: rtl/rotate_buffer_scheduler.sv
// Triple-buffer ownership scheduler for the rotation frame store.
// Three regions of BUFSIZE words share one RAM. The writer fills one region,
// the reader scans another, and the third holds the most recently completed
// frame (pending). Completed writer frames swap into pending; reader frame
// requests take pending if it is fresh, otherwise the reader repeats.
//   clk, reset        : clock, synchronous active-high reset
//   enable            : 0 ignores writer events and holds indices
//   wr_hbl, wr_vbl    : writer blanking levels
//   rd_frame_req      : reader starting an output frame (pulse)
//   stat_clr          : zero the statistics counters
//   wr_buf, rd_buf    : region indices for writer and reader
//   wr_base, rd_base  : region base addresses, registered with the indices
//   new_frame         : rd_buf now holds a freshly published frame (pulse)
//   drop_cnt          : published frames overwritten unread (saturating)
//   repeat_cnt        : reader requests with nothing new (saturating)
//   bad_cnt           : incomplete writer frames discarded (saturating)
//
// state | meaning
// SYNC  | waiting for a frame boundary; the partial frame in flight is thrown away
// RUN   | frame ends publish complete frames or count them as bad
module rotate_buffer_scheduler
    import rotate_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    localparam int BUFSIZE = WIDTH * HEIGHT,
    localparam int AW      = $clog2(3 * BUFSIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_hbl,
    input  logic          wr_vbl,
    input  logic          rd_frame_req,
    input  logic          stat_clr,
    output logic [1:0]    wr_buf,
    output logic [1:0]    rd_buf,
    output logic [AW-1:0] wr_base,
    output logic [AW-1:0] rd_base,
    output logic          new_frame,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    repeat_cnt,
    output logic [7:0]    bad_cnt
);

    logic frame_end;
    logic frame_ok;

    rotate_frame_validator #(
        .HEIGHT (HEIGHT)
    ) u_validator (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_hbl    (wr_hbl),
        .wr_vbl    (wr_vbl),
        .frame_end (frame_end),
        .frame_ok  (frame_ok)
    );

    state_t        state_q, state_d;
    buf_idx_t      wr_buf_q, wr_buf_d;
    buf_idx_t      rd_buf_q, rd_buf_d;
    buf_idx_t      p_buf_q, p_buf_d;
    logic          pend_valid_q, pend_valid_d;
    logic          new_frame_q, new_frame_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    repeat_cnt_q, repeat_cnt_d;
    logic [7:0]    bad_cnt_q, bad_cnt_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] rd_base_q, rd_base_d;

    always_comb begin
        state_d      = state_q;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        p_buf_d      = p_buf_q;
        pend_valid_d = pend_valid_q;
        new_frame_d  = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        if (enable) begin
            if (frame_end) begin
                if (state_q == SYNC) begin
                    state_d = RUN;
                end else if (frame_ok) begin
                    wr_buf_d     = p_buf_q;
                    p_buf_d      = wr_buf_q;
                    pend_valid_d = 1'b1;
                    if (pend_valid_q) begin
                        drop_cnt_d = sat_inc8(drop_cnt_q);
                    end
                end else begin
                    bad_cnt_d = sat_inc8(bad_cnt_q);
                end
            end
            // Reader update works on the writer's result so a frame published
            // this very cycle goes straight to the reader.
            if (rd_frame_req) begin
                if (pend_valid_d) begin
                    rd_buf_d     = p_buf_d;
                    p_buf_d      = rd_buf_q;
                    pend_valid_d = 1'b0;
                    new_frame_d  = 1'b1;
                end else begin
                    repeat_cnt_d = sat_inc8(repeat_cnt_q);
                end
            end
        end else begin
            state_d = SYNC;
            if (rd_frame_req) begin
                repeat_cnt_d = sat_inc8(repeat_cnt_q);
            end
        end

        if (stat_clr) begin
            drop_cnt_d   = '0;
            repeat_cnt_d = '0;
            bad_cnt_d    = '0;
        end

        wr_base_d = AW'(buf_base(wr_buf_d, BUFSIZE));
        rd_base_d = AW'(buf_base(rd_buf_d, BUFSIZE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            wr_buf_q     <= BUF_W_RST;
            rd_buf_q     <= BUF_R_RST;
            p_buf_q      <= BUF_P_RST;
            pend_valid_q <= 1'b0;
            new_frame_q  <= 1'b0;
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
            bad_cnt_q    <= '0;
            wr_base_q    <= AW'(buf_base(BUF_W_RST, BUFSIZE));
            rd_base_q    <= AW'(buf_base(BUF_R_RST, BUFSIZE));
        end else begin
            state_q      <= state_d;
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
            p_buf_q      <= p_buf_d;
            pend_valid_q <= pend_valid_d;
            new_frame_q  <= new_frame_d;
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            wr_base_q    <= wr_base_d;
            rd_base_q    <= rd_base_d;
        end
    end

    assign wr_buf     = wr_buf_q;
    assign rd_buf     = rd_buf_q;
    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign new_frame  = new_frame_q;
    assign drop_cnt   = drop_cnt_q;
    assign repeat_cnt = repeat_cnt_q;
    assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_rotate_buffer_scheduler.sv
// Bench for rotate_buffer_scheduler with WIDTH=4, HEIGHT=4.
// A role-based reference model (which region each role owns) is advanced on
// every clock from the same inputs and compared against every output.
module tb_rotate_buffer_scheduler;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int BS  = W * H;
    localparam int AW  = $clog2(3 * BS);

    localparam int ROLE_W = 0;
    localparam int ROLE_R = 1;
    localparam int ROLE_P = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          wr_hbl = 1'b0;
    logic          wr_vbl = 1'b0;
    logic          rd_frame_req = 1'b0;
    logic          stat_clr = 1'b0;
    logic [1:0]    wr_buf;
    logic [1:0]    rd_buf;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic          new_frame;
    logic [7:0]    drop_cnt;
    logic [7:0]    repeat_cnt;
    logic [7:0]    bad_cnt;

    rotate_buffer_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .wr_hbl       (wr_hbl),
        .wr_vbl       (wr_vbl),
        .rd_frame_req (rd_frame_req),
        .stat_clr     (stat_clr),
        .wr_buf       (wr_buf),
        .rd_buf       (rd_buf),
        .wr_base      (wr_base),
        .rd_base      (rd_base),
        .new_frame    (new_frame),
        .drop_cnt     (drop_cnt),
        .repeat_cnt   (repeat_cnt),
        .bad_cnt      (bad_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // region owned by each role
    int m_region [3];
    bit m_pend, m_sync, m_nf, m_prev_h, m_prev_v;
    int m_lines, m_drop, m_rep, m_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic swap_roles(input int a, input int b);
        int t;
        t = m_region[a];
        m_region[a] = m_region[b];
        m_region[b] = t;
    endtask

    task automatic model_reset();
        m_region[ROLE_W] = 0;
        m_region[ROLE_R] = 1;
        m_region[ROLE_P] = 2;
        m_pend = 0; m_sync = 1; m_nf = 0;
        m_prev_h = 0; m_prev_v = 0;
        m_lines = 0; m_drop = 0; m_rep = 0; m_bad = 0;
    endtask

    task automatic model_step();
        bit line_ev, fe;
        if (reset) begin
            model_reset();
            return;
        end
        line_ev = wr_hbl && !m_prev_h && !wr_vbl;
        fe      = wr_vbl && !m_prev_v;
        m_nf    = 0;
        if (!enable) begin
            m_sync = 1;
            if (rd_frame_req) m_rep = sat(m_rep);
        end else begin
            if (fe) begin
                if (m_sync) begin
                    m_sync = 0;
                end else if (m_lines >= H) begin
                    if (m_pend) m_drop = sat(m_drop);
                    swap_roles(ROLE_W, ROLE_P);
                    m_pend = 1;
                end else begin
                    m_bad = sat(m_bad);
                end
            end
            if (rd_frame_req) begin
                if (m_pend) begin
                    swap_roles(ROLE_R, ROLE_P);
                    m_pend = 0;
                    m_nf = 1;
                end else begin
                    m_rep = sat(m_rep);
                end
            end
        end
        if (!enable || fe) m_lines = 0;
        else if (line_ev) m_lines++;
        m_prev_h = wr_hbl;
        m_prev_v = wr_vbl;
        if (stat_clr) begin
            m_drop = 0; m_rep = 0; m_bad = 0;
        end
    endtask

    task automatic compare_all();
        chk("wr_buf", 32'(wr_buf), 32'(m_region[ROLE_W]));
        chk("rd_buf", 32'(rd_buf), 32'(m_region[ROLE_R]));
        chk("p_buf", 32'(dut.p_buf_q), 32'(m_region[ROLE_P]));
        chk("wr_base", 32'(wr_base), 32'(m_region[ROLE_W] * BS));
        chk("rd_base", 32'(rd_base), 32'(m_region[ROLE_R] * BS));
        chk("new_frame", 32'(new_frame), 32'(m_nf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
        chk("bad_cnt", 32'(bad_cnt), 32'(m_bad));
        chk("perm", 32'((wr_buf != rd_buf) && (wr_buf != dut.p_buf_q) &&
                        (rd_buf != dut.p_buf_q) && (wr_buf < 3) &&
                        (rd_buf < 3) && (dut.p_buf_q < 3)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_line();
        wr_hbl = 1'b1; tick(); tick();
        wr_hbl = 1'b0; tick(); tick();
    endtask

    task automatic do_frame(input int nlines);
        for (int i = 0; i < nlines; i++) do_line();
        wr_vbl = 1'b1; tick(); tick(); tick();
        wr_vbl = 1'b0; tick();
    endtask

    task automatic req_pulse();
        rd_frame_req = 1'b1; tick();
        rd_frame_req = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_wr_buf", 32'(wr_buf), 32'd0);
        chk("rst_rd_buf", 32'(rd_buf), 32'd1);
        chk("rst_rd_base", 32'(rd_base), 32'(BS));
        tick();

        // two complete frames after the SYNC frame, nobody reading
        do_frame(H);
        do_frame(H);
        chk("s1_wr_after_first", 32'(wr_buf), 32'd2);
        do_frame(H);
        chk("s1_wr_after_second", 32'(wr_buf), 32'd0);
        chk("s1_drop", 32'(drop_cnt), 32'd1);

        // publish then read 5 clocks later
        do_reset();
        do_frame(H);
        do_frame(H);
        repeat (5) tick();
        req_pulse();
        chk("s2_rd_buf", 32'(rd_buf), 32'd0);
        chk("s2_rd_base", 32'(rd_base), 32'd0);
        chk("s2_nf_high", 32'(new_frame), 32'd1);
        tick();
        chk("s2_nf_one_clk", 32'(new_frame), 32'd0);
        req_pulse();
        chk("s2_repeat", 32'(repeat_cnt), 32'd1);
        chk("s2_rd_hold", 32'(rd_buf), 32'd0);

        // short frame is discarded
        do_frame(H - 1);
        chk("s3_bad", 32'(bad_cnt), 32'd1);
        chk("s3_wr_hold", 32'(wr_buf), 32'd2);
        req_pulse();
        chk("s3_no_nf", 32'(new_frame), 32'd0);

        // frame end and request in the same cycle with a pending frame
        do_reset();
        do_frame(H);
        do_frame(H);
        do_frame(H);
        for (int i = 0; i < H; i++) do_line();
        wr_vbl = 1'b1; rd_frame_req = 1'b1;
        tick();
        rd_frame_req = 1'b0;
        chk("s4_wr", 32'(wr_buf), 32'd2);
        chk("s4_rd", 32'(rd_buf), 32'd0);
        chk("s4_p", 32'(dut.p_buf_q), 32'd1);
        chk("s4_drop", 32'(drop_cnt), 32'd2);
        chk("s4_nf", 32'(new_frame), 32'd1);
        tick(); tick();
        wr_vbl = 1'b0; tick();

        // repeat counter saturation and clear winning over increment
        for (int i = 0; i < 300; i++) begin
            req_pulse();
            tick();
        end
        chk("s5_rep_sat", 32'(repeat_cnt), 32'd255);
        stat_clr = 1'b1; rd_frame_req = 1'b1;
        tick();
        stat_clr = 1'b0; rd_frame_req = 1'b0;
        chk("s5_rep_clr", 32'(repeat_cnt), 32'd0);

        // reset mid-line with a pending frame
        do_frame(H);
        wr_hbl = 1'b1; tick();
        reset = 1'b1; tick();
        reset = 1'b0; wr_hbl = 1'b0;
        chk("s6_wr", 32'(wr_buf), 32'd0);
        chk("s6_rd", 32'(rd_buf), 32'd1);
        chk("s6_wr_base", 32'(wr_base), 32'd0);
        chk("s6_rd_base", 32'(rd_base), 32'(BS));
        chk("s6_cnts", 32'({drop_cnt, repeat_cnt, bad_cnt}), 32'd0);
        tick();

        // random traffic
        for (int i = 0; i < 1000; i++) begin
            wr_hbl       = ($urandom_range(1, 0) == 1);
            wr_vbl       = ($urandom_range(15, 0) == 0);
            rd_frame_req = ($urandom_range(7, 0) == 0);
            enable       = ($urandom_range(31, 0) != 0);
            stat_clr     = ($urandom_range(63, 0) == 0);
            reset        = ($urandom_range(255, 0) == 0);
            tick();
        end
        reset = 1'b0; enable = 1'b1; wr_hbl = 1'b0; wr_vbl = 1'b0;
        rd_frame_req = 1'b0; stat_clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
